instruction_fetch: RTL and testbench

- Front-end stage directly upstream of the instruction decoder.
- Owns the PC and issues sequential word fetches to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers them in a small FIFO, presenting {instr, pc} to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute by flushing buffered and in-flight fetches.

---
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, issues credit-limited imem fetches, buffers in-order responses for decode.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect target stops fetching and yields one trapping NOP entry.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
module instruction_fetch #(
    parameter logic [`DATA_WIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [`DATA_WIDTH-1:0]   imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [`INSTR_WIDTH-1:0]  imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [`DATA_WIDTH-1:0]   redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [`INSTR_WIDTH-1:0]  out_instr,
`ifdef IF_MISALIGN_TRAP_EN
    output logic                     out_misaligned,
`endif
    output logic [`DATA_WIDTH-1:0]   out_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [`DATA_WIDTH-1:0] pc, resp_pc, target;
    logic [CW-1:0] outstanding, drop_cnt, count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [`INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [`DATA_WIDTH-1:0] pc_mem [FIFO_DEPTH];
    logic credit_ok, fetch_en, accept, kept, trap_push, push, pop, empty;
    logic [`INSTR_WIDTH-1:0] push_instr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(FIFO_DEPTH);
    assign imem_req_valid = rstn && credit_ok && fetch_en && !redirect_valid;
    assign imem_req_addr = pc;
    assign accept = imem_req_valid && imem_req_ready;
    assign kept = imem_rsp_valid && !redirect_valid && drop_cnt == '0;
    assign push = kept || trap_push;
    assign push_instr = trap_push ? `INSTR_WIDTH'(32'h0000_0013) : imem_rsp_data;
    assign empty = count == '0;
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    assign out_instr = empty ? '0 : instr_mem[rd_ptr];
    assign out_pc = empty ? '0 : pc_mem[rd_ptr];

`ifdef IF_MISALIGN_TRAP_EN
    logic trap, trap_pend;
    logic mis_mem [FIFO_DEPTH];
    assign target = redirect_pc;
    assign fetch_en = !trap;
    // Stale responses are already drained once nothing is outstanding.
    assign trap_push = trap_pend && outstanding == '0 && !redirect_valid;
    assign out_misaligned = !empty && mis_mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (push) mis_mem[wr_ptr] <= trap_push;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trap <= 1'b0;
            trap_pend <= 1'b0;
        end else if (redirect_valid) begin
            trap <= |redirect_pc[1:0];
            trap_pend <= |redirect_pc[1:0];
        end else if (trap_push) begin
            trap_pend <= 1'b0;
        end
    end
`else
    assign target = redirect_pc & ~`DATA_WIDTH'(3);
    assign fetch_en = 1'b1;
    assign trap_push = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr] <= resp_pc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc <= target;
                resp_pc <= target;
                // Every request still in flight after this cycle is stale.
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
                count <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept) pc <= pc + `DATA_WIDTH'(4);
                if (kept) resp_pc <= resp_pc + `DATA_WIDTH'(4);
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
                if (push) wr_ptr <= nxt(wr_ptr);
                if (pop) rd_ptr <= nxt(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: per-cycle vector table plus hand sequences against a bench-side in-order memory model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, out_valid, out_ready;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_instr, out_pc;
    logic req_valid2, out_valid2;
    logic [31:0] req_addr2, out_instr2, out_pc2;
`ifdef IF_MISALIGN_TRAP_EN
    logic out_misaligned, out_misaligned2;
`endif

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
`ifdef IF_MISALIGN_TRAP_EN
        .out_misaligned(out_misaligned),
`endif
        .out_pc(out_pc)
    );

    // Shares all inputs with dut; control behaviour is PC-independent so handshakes line up.
    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr2),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
`ifdef IF_MISALIGN_TRAP_EN
        .out_misaligned(out_misaligned2),
`endif
        .out_pc(out_pc2)
    );

    typedef struct {
        logic rst;
        int lat;
        logic rv;
        logic [31:0] rpc;
        logic ordy;
        logic erv;
        logic [31:0] eaddr;
        logic eov;
        logic [31:0] epc;
    } vec_t;
    typedef struct {
        logic [31:0] addr;
        int due;
    } mreq_t;

    vec_t v[$];
    mreq_t q[$];
    int lat, cyc, checks, errors;
    logic acc, s_rv, s_ov, s2_rv, s2_ov, s_mis;
    logic [31:0] acc_addr, s_addr, s_pc, s_instr, s2_addr, s2_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input int l, input logic rv, input logic [31:0] rpc, input logic ordy,
                       input logic erv, input logic [31:0] eaddr, input logic eov, input logic [31:0] epc);
        vec_t t;
        t.rst = rst; t.lat = l; t.rv = rv; t.rpc = rpc; t.ordy = ordy;
        t.erv = erv; t.eaddr = eaddr; t.eov = eov; t.epc = epc;
        v.push_back(t);
    endtask

    task automatic do_reset(input int l);
        rstn = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        lat = l;
        q.delete();
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_instr", out_instr, 32'd0);
        chk("reset out_pc", out_pc, 32'd0);
        rstn = 1'b1;
    endtask

    // One cycle: drive inputs, sample mid-cycle, then advance the memory model past the edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic ordy);
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = ordy;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_ov = out_valid; s_pc = out_pc; s_instr = out_instr;
        s2_rv = req_valid2; s2_addr = req_addr2; s2_ov = out_valid2; s2_pc = out_pc2;
`ifdef IF_MISALIGN_TRAP_EN
        s_mis = out_misaligned;
`else
        s_mis = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (imem_rsp_valid) q.delete(0);
        if (acc) begin
            mreq_t m;
            m.addr = acc_addr;
            m.due = cyc + lat;
            q.push_back(m);
        end
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        if (q.size() > 0) begin
            if (q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = q[0].addr ^ 32'hA5A5_0000;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn && dut.push && dut.count == 2) begin
            errors++;
            $display("FAIL fifo_overflow: push while full at cycle %0d", cyc);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        imem_req_ready = 1'b1;
        // Streaming, latency 1, decode always ready.
        add(1, 1, 0, 0, 1, 1, 32'h0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 32'h4, 0, 0);
        add(0, 1, 0, 0, 1, 0, 32'h8, 1, 32'h0);
        add(0, 1, 0, 0, 1, 1, 32'h8, 1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 32'hC, 0, 0);
        add(0, 1, 0, 0, 1, 0, 32'h10, 1, 32'h8);
        add(0, 1, 0, 0, 1, 1, 32'h10, 1, 32'hC);
        add(0, 1, 0, 0, 1, 1, 32'h14, 0, 0);
        // Decode stalled 10 cycles, then released.
        add(1, 1, 0, 0, 0, 1, 32'h0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 32'h4, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0);
        add(0, 1, 0, 0, 1, 0, 32'h8, 1, 32'h0);
        add(0, 1, 0, 0, 1, 1, 32'h8, 1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 32'hC, 0, 0);
        // Latency 3, redirect with two requests in flight.
        add(1, 3, 0, 0, 1, 1, 32'h0, 0, 0);
        add(0, 3, 0, 0, 1, 1, 32'h4, 0, 0);
        add(0, 3, 1, 32'h100, 1, 0, 32'h8, 0, 0);
        add(0, 3, 0, 0, 1, 0, 32'h100, 0, 0);
        add(0, 3, 0, 0, 1, 1, 32'h100, 0, 0);
        add(0, 3, 0, 0, 1, 1, 32'h104, 0, 0);
        add(0, 3, 0, 0, 1, 0, 32'h108, 0, 0);
        add(0, 3, 0, 0, 1, 0, 32'h108, 0, 0);
        add(0, 3, 0, 0, 1, 0, 32'h108, 1, 32'h100);
        add(0, 3, 0, 0, 1, 1, 32'h108, 1, 32'h104);
        // Redirect coinciding with a response and a pop.
        add(1, 1, 0, 0, 1, 1, 32'h0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 32'h4, 0, 0);
        add(0, 1, 1, 32'h200, 1, 0, 32'h8, 1, 32'h0);
        add(0, 1, 0, 0, 1, 1, 32'h200, 0, 0);
        add(0, 1, 0, 0, 1, 1, 32'h204, 0, 0);
        add(0, 1, 0, 0, 1, 0, 32'h208, 1, 32'h200);
        add(0, 1, 0, 0, 1, 1, 32'h208, 1, 32'h204);
        // Back-to-back redirects, latency 3.
        add(1, 3, 0, 0, 1, 1, 32'h0, 0, 0);
        add(0, 3, 0, 0, 1, 1, 32'h4, 0, 0);
        add(0, 3, 1, 32'h100, 1, 0, 32'h8, 0, 0);
        add(0, 3, 1, 32'h300, 1, 0, 32'h100, 0, 0);
        add(0, 3, 0, 0, 1, 1, 32'h300, 0, 0);
        add(0, 3, 0, 0, 1, 1, 32'h304, 0, 0);
        add(0, 3, 0, 0, 1, 0, 32'h308, 0, 0);
        add(0, 3, 0, 0, 1, 0, 32'h308, 0, 0);
        add(0, 3, 0, 0, 1, 0, 32'h308, 1, 32'h300);
        add(0, 3, 0, 0, 1, 1, 32'h308, 1, 32'h304);

        foreach (v[i]) begin
            if (v[i].rst) do_reset(v[i].lat);
            step(v[i].rv, v[i].rpc, v[i].ordy);
            chk($sformatf("row%0d req_valid", i), {31'b0, s_rv}, {31'b0, v[i].erv});
            chk($sformatf("row%0d req_addr", i), s_addr, v[i].eaddr);
            chk($sformatf("row%0d out_valid", i), {31'b0, s_ov}, {31'b0, v[i].eov});
            if (v[i].eov) begin
                chk($sformatf("row%0d out_pc", i), s_pc, v[i].epc);
                chk($sformatf("row%0d out_instr", i), s_instr, v[i].epc ^ 32'hA5A5_0000);
            end
        end

        // RESET_PC near the top of the address space wraps to zero.
        do_reset(1);
        step(0, 0, 1);
        chk("wrap c0 req_valid", {31'b0, s2_rv}, 32'd1);
        chk("wrap c0 addr", s2_addr, 32'hFFFF_FFF8);
        step(0, 0, 1);
        chk("wrap c1 addr", s2_addr, 32'hFFFF_FFFC);
        step(0, 0, 1);
        chk("wrap c2 out_pc", s2_ov ? s2_pc : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("wrap c2 addr", s2_addr, 32'h0);
        step(0, 0, 1);
        chk("wrap c3 req_valid", {31'b0, s2_rv}, 32'd1);
        chk("wrap c3 addr", s2_addr, 32'h0);

        // Misaligned redirect target.
        do_reset(1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 32'h102, 1);
`ifdef IF_MISALIGN_TRAP_EN
        step(0, 0, 1);
        chk("mis c3 req_valid", {31'b0, s_rv}, 32'd0);
        step(0, 0, 1);
        chk("mis c4 req_valid", {31'b0, s_rv}, 32'd0);
        chk("mis c4 out_valid", {31'b0, s_ov}, 32'd1);
        chk("mis c4 out_pc", s_pc, 32'h102);
        chk("mis c4 out_instr", s_instr, 32'h13);
        chk("mis c4 out_misaligned", {31'b0, s_mis}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1);
            chk($sformatf("mis idle%0d req_valid", k), {31'b0, s_rv}, 32'd0);
            chk($sformatf("mis idle%0d out_valid", k), {31'b0, s_ov}, 32'd0);
        end
`else
        step(0, 0, 1);
        chk("mis c3 req_valid", {31'b0, s_rv}, 32'd1);
        chk("mis c3 addr", s_addr, 32'h100);
        step(0, 0, 1);
        chk("mis c4 addr", s_addr, 32'h104);
        step(0, 0, 1);
        chk("mis c5 out_valid", {31'b0, s_ov}, 32'd1);
        chk("mis c5 out_pc", s_pc, 32'h100);
        chk("mis c5 out_instr", s_instr, 32'h100 ^ 32'hA5A5_0000);
        chk("mis c5 out_misaligned", {31'b0, s_mis}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
